// File: rtl/snes_pkg.sv
// snes_pkg: shared FSM states, button bit positions and timing helper for the SNES pad reader
package snes_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;
  localparam int BTN_B = 0;
  localparam int BTN_Y = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP = 4;
  localparam int BTN_DOWN = 5;
  localparam int BTN_LEFT = 6;
  localparam int BTN_RIGHT = 7;
  localparam int BTN_A = 8;
  localparam int BTN_X = 9;
  localparam int BTN_L = 10;
  localparam int BTN_R = 11;
  function automatic int us_to_cyc(input int clk_hz, input int us);
    return clk_hz / 1_000_000 * us;
  endfunction
endpackage

// File: rtl/snes_pad_lane.sv
// snes_pad_lane: per-pad synchroniser, bit capture, presence detect and button edge strobes
module snes_pad_lane #(
  parameter int NUM_BITS = 16,
  parameter int KW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data,
  input  logic                sample,
  input  logic                publish,
  input  logic [KW-1:0]       k,
  output logic [NUM_BITS-1:0] buttons,
  output logic [NUM_BITS-1:0] pressed,
  output logic [NUM_BITS-1:0] released,
  output logic                present
);
  logic s1, s2, here;
  logic [NUM_BITS-1:0] sh, nxt;
  // an unplugged pad is pulled low, so every captured bit reads as pressed
  assign here = ~&sh;
  assign nxt = here ? sh : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      sh <= '0;
      buttons <= '0;
      pressed <= '0;
      released <= '0;
      present <= 1'b0;
    end else begin
      s1 <= data;
      s2 <= s1;
      if (sample) sh[k] <= ~s2;
      pressed <= publish ? nxt & ~buttons : '0;
      released <= publish ? ~nxt & buttons : '0;
      if (publish) begin
        buttons <= nxt;
        present <= here;
      end
    end
  end
endmodule

// File: rtl/snes_multi_reader.sv
// snes_multi_reader: polls NUM_PADS SNES pads over a shared latch/pulse pair with auto-poll
module snes_multi_reader
  import snes_pkg::*;
#(
  parameter int NUM_PADS = 2,
  parameter int NUM_BITS = 16,
  parameter int CLK_HZ = 50_000_000,
  parameter int LATCH_US = 12,
  parameter int HALF_US = 6,
  parameter int POLL_HZ = 60
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         auto_en,
  input  logic [NUM_PADS-1:0]          data,
  output logic                         latch,
  output logic                         pulse,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] released,
  output logic [NUM_PADS-1:0]          present,
  output logic                         valid,
  output logic                         busy
);
  localparam int LATCH_CYC = us_to_cyc(CLK_HZ, LATCH_US);
  localparam int HALF_CYC = us_to_cyc(CLK_HZ, HALF_US);
  localparam int POLL_CYC = CLK_HZ / POLL_HZ;
  localparam int MAXC = LATCH_CYC > HALF_CYC ? LATCH_CYC : HALF_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam int PW = $clog2(POLL_CYC + 1);
  localparam int KW = $clog2(NUM_BITS);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [KW-1:0] k, k_n;
  logic [PW-1:0] poll;
  logic pending, pending_n, tick, req, last, sample;
  assign tick = auto_en && poll == PW'(POLL_CYC - 1);
  assign req = start | tick;
  assign latch = state == LATCH;
  assign pulse = state == HIGH;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    k_n = k;
    sample = 1'b0;
    last = cnt == CW'(((state == LATCH) ? LATCH_CYC : HALF_CYC) - 1);
    // requests arriving mid-frame collapse into a single deferred frame
    pending_n = (state == IDLE) ? 1'b0 : pending | req;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (req || pending) state_n = LATCH;
      end
      LATCH: if (last) begin
        state_n = LOW;
        cnt_n = '0;
        k_n = '0;
      end
      LOW: if (last) begin
        sample = 1'b1;
        cnt_n = '0;
        state_n = (k == KW'(NUM_BITS - 1)) ? DONE : HIGH;
      end
      HIGH: if (last) begin
        state_n = LOW;
        cnt_n = '0;
        k_n = k + 1'b1;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      k <= '0;
      pending <= 1'b0;
      poll <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      k <= k_n;
      pending <= pending_n;
      poll <= auto_en ? (tick ? '0 : poll + 1'b1) : '0;
      valid <= state == DONE;
    end
  end
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_lane
    snes_pad_lane #(.NUM_BITS(NUM_BITS), .KW(KW)) u_lane (
      .clk(clk),
      .rst(rst),
      .data(data[p]),
      .sample(sample),
      .publish(state == DONE),
      .k(k),
      .buttons(buttons[p*NUM_BITS +: NUM_BITS]),
      .pressed(pressed[p*NUM_BITS +: NUM_BITS]),
      .released(released[p*NUM_BITS +: NUM_BITS]),
      .present(present[p])
    );
  end
endmodule

// File: tb/tb_snes_multi_reader.sv
// tb_snes_multi_reader: directed frames against a two-pad model with hand-computed results
module tb_snes_multi_reader;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, auto_en = 1'b0;
  logic [1:0] data;
  logic latch, pulse, valid, busy;
  logic [31:0] buttons, pressed, released;
  logic [1:0] present;
  logic [15:0] pad [2];
  logic tie1 = 1'b0;
  int idx = 16;
  logic pl = 1'b0, pp = 1'b0;
  int checks = 0, failures = 0;
  int vcnt, lrcnt, lhigh, prcnt, quiet_bad = 0;
  int v_at [8];
  int lr_at [8];
  logic [31:0] cb, cp, cr;
  logic [1:0] cpres;
  logic pl_s, pp_s;

  always #5 clk = ~clk;

  snes_multi_reader #(
    .NUM_PADS(2), .NUM_BITS(16), .CLK_HZ(1_000_000),
    .LATCH_US(2), .HALF_US(1), .POLL_HZ(20000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .data(data),
    .latch(latch), .pulse(pulse), .buttons(buttons), .pressed(pressed),
    .released(released), .present(present), .valid(valid), .busy(busy)
  );

  // pad model runs one bit ahead of the shift edges so the reader's
  // two-flop synchroniser lands each bit k in its own capture slot
  always @(posedge clk) begin
    #1;
    if (latch) idx = 0;
    else if (pl) idx = 1;
    else if (pulse && !pp) idx++;
    pl = latch;
    pp = pulse;
  end
  always_comb begin
    data[0] = (idx >= 0 && idx < 16) ? ~pad[0][idx[3:0]] : 1'b1;
    data[1] = tie1 ? 1'b0 : ((idx >= 0 && idx < 16) ? ~pad[1][idx[3:0]] : 1'b1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic watch(input int n, input logic [127:0] sm, input int alen);
    vcnt = 0; lrcnt = 0; lhigh = 0; prcnt = 0;
    pl_s = latch; pp_s = pulse;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (latch && !pl_s) begin
          if (lrcnt < 8) lr_at[lrcnt] = i;
          lrcnt++;
        end
        if (latch) lhigh++;
        if (pulse && !pp_s) prcnt++;
        if (valid) begin
          if (vcnt < 8) v_at[vcnt] = i;
          vcnt++;
          cb = buttons; cp = pressed; cr = released; cpres = present;
        end else if ((pressed | released) != 0) quiet_bad++;
      end
      pl_s = latch; pp_s = pulse;
      start = (i < 128) ? sm[i] : 1'b0;
      auto_en = i < alen;
    end
  endtask

  initial begin
    pad[0] = 16'h0000; pad[1] = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_latch", latch, 0);
    check("rst_pulse", pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_buttons", buttons, 0);
    check("rst_present", present, 0);
    rst = 1'b1;

    pad[0] = 16'h0009; pad[1] = 16'h0000;
    watch(60, 1, 0);
    check("f1_latch_rise", lr_at[0], 1);
    check("f1_latch_cycles", lhigh, 2);
    check("f1_pulse_rises", prcnt, 15);
    check("f1_valid_count", vcnt, 1);
    check("f1_valid_at", v_at[0], 35);
    check("f1_buttons", cb, 32'h0000_0009);
    check("f1_present", cpres, 2'b11);
    check("f1_pressed", cp, 32'h0000_0009);
    check("f1_released", cr, 32'h0);

    pad[0] = 16'h0008; pad[1] = 16'h0A05;
    watch(60, 1, 0);
    check("f2_buttons", cb, 32'h0A05_0008);
    check("f2_pressed", cp, 32'h0A05_0000);
    check("f2_released", cr, 32'h0000_0001);

    tie1 = 1'b1; pad[0] = 16'h0108;
    watch(60, 1, 0);
    check("f3_present", cpres, 2'b01);
    check("f3_buttons", cb, 32'h0000_0108);
    check("f3_pressed", cp, 32'h0000_0100);
    check("f3_released", cr, 32'h0A05_0000);

    tie1 = 1'b0; pad[1] = 16'h0000;
    watch(260, 0, 200);
    check("auto_valid_count", vcnt, 4);
    for (int j = 0; j < 3; j++) check("auto_gap", v_at[j+1] - v_at[j], 50);

    watch(100, 128'h8421, 0);
    check("coal_valid_count", vcnt, 2);
    check("coal_latch_rises", lrcnt, 2);
    check("coal_relaunch_at", lr_at[1], 36);
    check("coal_valid2_at", v_at[1], 70);

    watch(10, 1, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_latch", latch, 0);
    check("mid_rst_pulse", pulse, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_buttons", buttons, 0);
    check("mid_rst_present", present, 0);
    rst = 1'b1;
    watch(80, 0, 0);
    check("post_rst_valids", vcnt, 0);
    check("post_rst_latch", lrcnt, 0);
    check("post_rst_pulse", prcnt, 0);
    check("edge_quiet", quiet_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
